// File: rtl/car_warning_seq_pkg.sv
// Shared types and reset constants for the clocked car-warning sequencer.
// Filtered-input reset values describe a parked car: ignition off, doors shut, seats empty, belts fastened.
package car_warning_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      ALERT = 2'd2,
      MUTED = 2'd3
   } state_e;

   localparam logic IGN_RST_VAL  = 1'b0;
   localparam logic DOOR_RST_VAL = 1'b1;
   localparam logic OCC_RST_VAL  = 1'b0;
   localparam logic BELT_RST_VAL = 1'b1;

endpackage

// File: rtl/car_warning_seq_debounce.sv
// Single-bit debouncer: the filtered value follows raw only after DEBOUNCE_CYC consecutive differing samples.
module warn_debounce #(
   parameter int   DEBOUNCE_CYC = 4,
   parameter logic RESET_VAL    = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic filtered
);

   localparam int CW = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

   logic [CW-1:0] cnt;

   // The flip happens on the edge where the count would reach DEBOUNCE_CYC.
   always_ff @(posedge clk) begin
      if (rst) begin
         filtered <= RESET_VAL;
         cnt      <= '0;
      end else if (raw == filtered) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         filtered <= raw;
         cnt      <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/car_warning_seq.sv
// Debounced door/seat/belt warning sequencer with belt grace period, latched lamp,
// pulsed chime, driver mute and chime auto-timeout.
module car_warning_seq
   import car_warning_pkg::*;
#(
   parameter int NUM_DOORS    = 4,
   parameter int NUM_SEATS    = 2,
   parameter int DEBOUNCE_CYC = 4,
   parameter int GRACE_CYC    = 16,
   parameter int CHIME_HALF   = 8,
   parameter int TIMEOUT_CYC  = 64
) (
   input  logic                           Clk,
   input  logic                           Rst,
   input  logic                           Ignition,
   input  logic [NUM_DOORS-1:0]           DoorClose,
   input  logic [NUM_SEATS-1:0]           SeatOccupied,
   input  logic [NUM_SEATS-1:0]           SeatBelt,
   input  logic                           Ack,
   output logic                           Alarm,
   output logic                           Chime,
   output logic [NUM_DOORS+NUM_SEATS-1:0] FaultMask
);

   localparam int NF = NUM_DOORS + NUM_SEATS;
   localparam int GW = $clog2(GRACE_CYC + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int CW = $clog2(CHIME_HALF + 1);
   localparam logic [GW-1:0] GRACE_END  = GW'(GRACE_CYC);
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYC - 1);
   localparam logic [CW-1:0] CHIME_LAST = CW'(CHIME_HALF - 1);

   logic                 ign_f;
   logic [NUM_DOORS-1:0] door_f;
   logic [NUM_SEATS-1:0] occ_f;
   logic [NUM_SEATS-1:0] belt_f;

   warn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .RESET_VAL(IGN_RST_VAL)) u_ign_db (
      .clk(Clk), .rst(Rst), .raw(Ignition), .filtered(ign_f)
   );

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DOORS; gi++) begin : g_door
         warn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .RESET_VAL(DOOR_RST_VAL)) u_db (
            .clk(Clk), .rst(Rst), .raw(DoorClose[gi]), .filtered(door_f[gi])
         );
      end
      for (gi = 0; gi < NUM_SEATS; gi++) begin : g_seat
         warn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .RESET_VAL(OCC_RST_VAL)) u_occ_db (
            .clk(Clk), .rst(Rst), .raw(SeatOccupied[gi]), .filtered(occ_f[gi])
         );
         warn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .RESET_VAL(BELT_RST_VAL)) u_belt_db (
            .clk(Clk), .rst(Rst), .raw(SeatBelt[gi]), .filtered(belt_f[gi])
         );
      end
   endgenerate

   logic [GW-1:0] grace_cnt;
   logic          grace_done;
   assign grace_done = (grace_cnt == GRACE_END);

   logic [NUM_DOORS-1:0] door_open;
   logic [NUM_SEATS-1:0] belt_miss;
   logic [NF-1:0]        fault;
   logic                 any_fault;
   logic                 new_fault;

   // FaultMask is the registered copy of the fault vector, so it doubles as the previous-cycle value.
   assign door_open = {NUM_DOORS{ign_f}} & ~door_f;
   assign belt_miss = {NUM_SEATS{ign_f & grace_done}} & occ_f & ~belt_f;
   assign fault     = {belt_miss, door_open};
   assign any_fault = |fault;
   assign new_fault = |(fault & ~FaultMask);

   state_e        state;
   state_e        next_state;
   logic          enter_alert;
   logic [TW-1:0] tmo_cnt;
   logic [TW-1:0] tmo_next;
   logic [CW-1:0] chime_cnt;
   logic [CW-1:0] chime_next;
   logic          phase;
   logic          phase_next;

   always_comb begin
      next_state  = state;
      enter_alert = 1'b0;
      case (state)
         IDLE: begin
            if (ign_f) next_state = ARMED;
         end
         ARMED: begin
            if (!ign_f) begin
               next_state = IDLE;
            end else if (any_fault) begin
               next_state  = ALERT;
               enter_alert = 1'b1;
            end
         end
         ALERT: begin
            if (!ign_f)                  next_state = IDLE;
            else if (!any_fault)         next_state = ARMED;
            else if (Ack)                next_state = MUTED;
            else if (tmo_cnt == TMO_LAST) next_state = MUTED;
         end
         MUTED: begin
            if (!ign_f) begin
               next_state = IDLE;
            end else if (!any_fault) begin
               next_state = ARMED;
            end else if (new_fault) begin
               next_state  = ALERT;
               enter_alert = 1'b1;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Staying in ALERT without a fresh entry implies the current state is ALERT.
   always_comb begin
      tmo_next   = tmo_cnt;
      chime_next = chime_cnt;
      phase_next = phase;
      if (enter_alert) begin
         tmo_next   = '0;
         chime_next = '0;
         phase_next = 1'b1;
      end else if (next_state == ALERT) begin
         tmo_next = tmo_cnt + 1'b1;
         if (chime_cnt == CHIME_LAST) begin
            chime_next = '0;
            phase_next = ~phase;
         end else begin
            chime_next = chime_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state     <= IDLE;
         grace_cnt <= '0;
         tmo_cnt   <= '0;
         chime_cnt <= '0;
         phase     <= 1'b0;
         Alarm     <= 1'b0;
         Chime     <= 1'b0;
         FaultMask <= '0;
      end else begin
         state     <= next_state;
         tmo_cnt   <= tmo_next;
         chime_cnt <= chime_next;
         phase     <= phase_next;
         Alarm     <= (next_state == ALERT) || (next_state == MUTED);
         Chime     <= (next_state == ALERT) && phase_next;
         FaultMask <= fault;
         if (!ign_f)           grace_cnt <= '0;
         else if (!grace_done) grace_cnt <= grace_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_car_warning_seq.sv
// Directed bench for car_warning_seq: expected {Alarm, Chime, FaultMask} words are queued
// as each cycle's stimulus is applied and compared after the following clock edge.
module tb_car_warning_seq;
   import car_warning_pkg::*;

   logic       Clk = 1'b0;
   logic       Rst;
   logic       Ignition;
   logic [3:0] DoorClose;
   logic [1:0] SeatOccupied;
   logic [1:0] SeatBelt;
   logic       Ack;
   logic       Alarm;
   logic       Chime;
   logic [5:0] FaultMask;

   car_warning_seq #(
      .NUM_DOORS(4), .NUM_SEATS(2), .DEBOUNCE_CYC(4),
      .GRACE_CYC(16), .CHIME_HALF(8), .TIMEOUT_CYC(64)
   ) dut (
      .Clk(Clk), .Rst(Rst), .Ignition(Ignition), .DoorClose(DoorClose),
      .SeatOccupied(SeatOccupied), .SeatBelt(SeatBelt), .Ack(Ack),
      .Alarm(Alarm), .Chime(Chime), .FaultMask(FaultMask)
   );

   always #5 Clk = ~Clk;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] exp_q[$];
   string      tag_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [7:0] pack_out(input logic alarm, input logic chime, input logic [5:0] mask);
      return {alarm, chime, mask};
   endfunction

   task automatic expect_next(input string tag, input logic [7:0] exp);
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      @(posedge Clk);
      #1;
      if (exp_q.size() == 0) begin
         n_checks++;
         $display("FAIL scoreboard: queue empty at time %0t", $time);
      end else begin
         check(tag_q.pop_front(), {24'd0, Alarm, Chime, FaultMask}, {24'd0, exp_q.pop_front()});
      end
   endtask

   task automatic reset_dut();
      Ignition     = 1'b0;
      DoorClose    = 4'hF;
      SeatOccupied = 2'b00;
      SeatBelt     = 2'b11;
      Ack          = 1'b0;
      Rst          = 1'b1;
      repeat (2) begin
         @(posedge Clk);
         #1;
      end
      Rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Door open with ignition already on, then chime pulse train.
      reset_dut();
      check("reset_out", {24'd0, Alarm, Chime, FaultMask}, 32'd0);
      check("reset_state", 32'(dut.state), 32'(IDLE));
      Ignition = 1'b1;
      for (int k = 1; k <= 6; k++) expect_next("t1_ign_on", 8'h00);
      check("t1_state_armed", 32'(dut.state), 32'(ARMED));
      DoorClose[2] = 1'b0;
      for (int k = 1; k <= 24; k++) begin
         if (k < 5) expect_next("t1_debounce", 8'h00);
         else expect_next("t1_alert", pack_out(1'b1, (((k - 5) / 8) % 2) == 0, 6'b000100));
      end

      // Ack mutes; a new door fault together with Ack re-alerts; then timeout mutes.
      Ack = 1'b1;
      expect_next("t3_ack", pack_out(1'b1, 1'b0, 6'b000100));
      Ack = 1'b0;
      for (int k = 1; k <= 3; k++) expect_next("t3_muted", pack_out(1'b1, 1'b0, 6'b000100));
      DoorClose[0] = 1'b0;
      for (int k = 1; k <= 70; k++) begin
         Ack = (k == 5);
         if (k < 5) expect_next("t3_muted_db", pack_out(1'b1, 1'b0, 6'b000100));
         else if (k - 5 < 64) expect_next("t3_realert", pack_out(1'b1, (((k - 5) / 8) % 2) == 0, 6'b000101));
         else expect_next("t4_timeout", pack_out(1'b1, 1'b0, 6'b000101));
      end
      Ack = 1'b0;
      check("t4_state_muted", 32'(dut.state), 32'(MUTED));
      DoorClose = 4'hF;
      for (int k = 1; k <= 5; k++) begin
         if (k < 5) expect_next("t4_closing", pack_out(1'b1, 1'b0, 6'b000101));
         else expect_next("t4_closed", 8'h00);
      end
      check("t4_state_armed", 32'(dut.state), 32'(ARMED));

      // Unbuckled occupied seat only counts after the grace period.
      reset_dut();
      Ignition     = 1'b1;
      SeatOccupied = 2'b10;
      SeatBelt     = 2'b01;
      for (int k = 1; k <= 21; k++) begin
         if (k < 21) expect_next("t2_grace", 8'h00);
         else expect_next("t2_belt", pack_out(1'b1, 1'b1, 6'b100000));
      end

      // Ack in ARMED is not stored, a short glitch is filtered, reset mid-alert.
      reset_dut();
      Ignition = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         Ack = (k == 7);
         expect_next("t5_armed_ack", 8'h00);
      end
      Ack = 1'b0;
      DoorClose[1] = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         if (k == 4) DoorClose[1] = 1'b1;
         expect_next("t5_glitch", 8'h00);
      end
      DoorClose[3] = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         if (k < 5) expect_next("t5_debounce", 8'h00);
         else expect_next("t5_alert", pack_out(1'b1, 1'b1, 6'b001000));
      end
      Rst = 1'b1;
      expect_next("t5_rst", 8'h00);
      Rst = 1'b0;
      check("t5_rst_state", 32'(dut.state), 32'(IDLE));
      for (int k = 1; k <= 6; k++) begin
         if (k < 5) expect_next("t5_redebounce", 8'h00);
         else if (k == 5) expect_next("t5_rearm", pack_out(1'b0, 1'b0, 6'b001000));
         else expect_next("t5_realert", pack_out(1'b1, 1'b1, 6'b001000));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
